// File: rtl/mem_ctrl.sv
// ---------------------------------------------------------------------------
// mem_ctrl
//
// Sole owner of the single-port, byte-wide external RAM. Two clients share it:
//   - the mem stage, whose byte accesses go straight to the RAM bus and always
//     win the bus in the cycle they are requested;
//   - the instruction-fetch stage, served by a small FSM that reads four bytes
//     (little-endian) in cycles the mem stage leaves free. A mem-stage access
//     in the middle of a fetch throws the partial word away and the fetch
//     restarts from the first byte.
//
// Optional feature (compile-time macro MEMCTRL_IO_STALL_EN):
//   Adds input io_buffer_full. A mem-stage write into IO space
//   (ma_addr_in[17:16] == 2'b11) is held off the RAM bus while the IO buffer
//   is full; the mem stage keeps ma_ce_flag high, so it simply stalls.
//
// Parameters:
//   RAM_ADDR_W  width of the external RAM byte address (upper bits dropped)
//   ADDR_W      width of CPU-side addresses
//
// Ports:
//   clk             system clock
//   rst             asynchronous, active-low reset
//   ma_addr_in      mem-stage byte address
//   ma_data_in      mem-stage write byte
//   ma_rw_flag      mem-stage direction, 1 = write, 0 = read
//   ma_ce_flag      mem-stage access request, held for the whole access
//   ma_data_out     read byte returned to the mem stage (RAM data, unregistered)
//   io_buffer_full  (MEMCTRL_IO_STALL_EN only) IO sink cannot take a write
//   if_req          fetch request, held until if_done or dropped as a flush
//   if_pc           fetch address, stable while if_req is high
//   if_done         one-cycle pulse, if_inst holds the new instruction
//   if_inst         last completely fetched instruction word
//   mem_din         RAM read data, valid one cycle after the address
//   mem_dout        RAM write data
//   mem_a           RAM byte address
//   mem_wr          RAM write enable, 1 = write
// ---------------------------------------------------------------------------
module mem_ctrl #(
    parameter int RAM_ADDR_W = 17,
    parameter int ADDR_W     = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_W-1:0]     ma_addr_in,
    input  logic [7:0]            ma_data_in,
    input  logic                  ma_rw_flag,
    input  logic                  ma_ce_flag,
    output logic [7:0]            ma_data_out,
`ifdef MEMCTRL_IO_STALL_EN
    input  logic                  io_buffer_full,
`endif
    input  logic                  if_req,
    input  logic [ADDR_W-1:0]     if_pc,
    output logic                  if_done,
    output logic [31:0]           if_inst,
    input  logic [7:0]            mem_din,
    output logic [7:0]            mem_dout,
    output logic [RAM_ADDR_W-1:0] mem_a,
    output logic                  mem_wr
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [2:0]         idx;
    logic [2:0]         idx_nxt;
    logic [2:0]         cap;
    logic [2:0]         cap_nxt;
    logic               pend;
    logic               pend_nxt;
    logic               cap_en;
    logic [23:0]        fetch_buf;
    logic [ADDR_W-1:0]  fetch_addr;
    logic               fetch_blocked;
    logic               io_block;
    logic               unused_addr_bits;

    // Fetch byte address is formed at full CPU width so that a PC near the
    // top of the address space wraps naturally before truncation.
    assign fetch_addr = if_pc + ADDR_W'(idx);

    // High address bits do not reach the RAM; they are intentionally ignored.
    assign unused_addr_bits = ^{ma_addr_in[ADDR_W-1:RAM_ADDR_W],
                                fetch_addr[ADDR_W-1:RAM_ADDR_W]};

    assign ma_data_out = mem_din;
    assign if_done     = (state == DONE);

`ifdef MEMCTRL_IO_STALL_EN
    logic io_hold;

    // An IO-space write is suppressed while the IO buffer is full. io_hold
    // remembers that a write was deferred so the fetch side also stays off
    // the bus until the deferred write has actually gone out.
    assign io_block = ma_ce_flag & ma_rw_flag & (ma_addr_in[17:16] == 2'b11)
                      & io_buffer_full;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            io_hold <= 1'b0;
        end else begin
            io_hold <= io_block;
        end
    end

    assign fetch_blocked = ma_ce_flag | io_hold;
`else
    assign io_block      = 1'b0;
    assign fetch_blocked = ma_ce_flag;
`endif

    // RAM bus mux: the mem stage owns the bus whenever it asks; otherwise the
    // fetch FSM drives the next byte address while it still has bytes to issue.
    always_comb begin
        mem_a    = '0;
        mem_dout = '0;
        mem_wr   = 1'b0;
        if (!rst) begin
            mem_a    = '0;
        end else if (ma_ce_flag) begin
            mem_a    = ma_addr_in[RAM_ADDR_W-1:0];
            mem_dout = ma_data_in;
            mem_wr   = ma_rw_flag & ~io_block;
        end else if (state == FETCH && idx < 3'd4) begin
            mem_a    = fetch_addr[RAM_ADDR_W-1:0];
        end
    end

    // Next-state logic. idx counts byte addresses issued in the current
    // attempt; pend marks that the byte addressed last cycle arrives on
    // mem_din now. Bytes are issued and captured strictly in order, so the
    // pending byte is always byte number cap.
    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        cap_nxt   = cap;
        pend_nxt  = pend;
        cap_en    = 1'b0;
        case (state)
            IDLE: begin
                if (if_req && !fetch_blocked) begin
                    state_nxt = FETCH;
                    idx_nxt   = 3'd0;
                    cap_nxt   = 3'd0;
                    pend_nxt  = 1'b0;
                end
            end
            FETCH: begin
                if (!if_req) begin
                    state_nxt = IDLE;
                    idx_nxt   = 3'd0;
                    cap_nxt   = 3'd0;
                    pend_nxt  = 1'b0;
                end else if (fetch_blocked) begin
                    idx_nxt   = 3'd0;
                    cap_nxt   = 3'd0;
                    pend_nxt  = 1'b0;
                end else begin
                    if (pend) begin
                        cap_en  = 1'b1;
                        cap_nxt = cap + 3'd1;
                    end
                    if (idx < 3'd4) begin
                        idx_nxt  = idx + 3'd1;
                        pend_nxt = 1'b1;
                    end else begin
                        pend_nxt = 1'b0;
                    end
                    if (pend && cap == 3'd3) begin
                        state_nxt = DONE;
                    end
                end
            end
            DONE: begin
                state_nxt = IDLE;
                idx_nxt   = 3'd0;
                cap_nxt   = 3'd0;
                pend_nxt  = 1'b0;
            end
            default: begin
                state_nxt = IDLE;
                idx_nxt   = 3'd0;
                cap_nxt   = 3'd0;
                pend_nxt  = 1'b0;
            end
        endcase
    end

    // State and datapath registers. The first three bytes collect in a
    // staging buffer so if_inst only changes when a whole word has arrived.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            idx       <= 3'd0;
            cap       <= 3'd0;
            pend      <= 1'b0;
            fetch_buf <= '0;
            if_inst   <= '0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
            cap   <= cap_nxt;
            pend  <= pend_nxt;
            if (cap_en) begin
                case (cap[1:0])
                    2'd0:    fetch_buf[7:0]   <= mem_din;
                    2'd1:    fetch_buf[15:8]  <= mem_din;
                    2'd2:    fetch_buf[23:16] <= mem_din;
                    default: if_inst          <= {mem_din, fetch_buf};
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mem_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mem_ctrl
//
// Self-checking bench for mem_ctrl. A synchronous byte RAM sits on the RAM
// bus. A transaction-level model tracks each fetch as "number of free cycles
// since the attempt began" and predicts the bus, if_done and if_inst from
// that; a compare process checks the DUT against it every cycle. Directed
// scenarios add hand-computed literal expectations.
// ---------------------------------------------------------------------------
module tb_mem_ctrl;

    localparam int RAM_ADDR_W = 17;
    localparam int ADDR_W     = 32;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [ADDR_W-1:0]     ma_addr_in;
    logic [7:0]            ma_data_in;
    logic                  ma_rw_flag;
    logic                  ma_ce_flag;
    logic [7:0]            ma_data_out;
    logic                  if_req;
    logic [ADDR_W-1:0]     if_pc;
    logic                  if_done;
    logic [31:0]           if_inst;
    logic [7:0]            mem_din;
    logic [7:0]            mem_dout;
    logic [RAM_ADDR_W-1:0] mem_a;
    logic                  mem_wr;
`ifdef MEMCTRL_IO_STALL_EN
    logic                  io_buffer_full;
`endif

    int checks = 0;
    int errors = 0;
    logic checkEn = 1'b0;

    mem_ctrl #(.RAM_ADDR_W(RAM_ADDR_W), .ADDR_W(ADDR_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .ma_addr_in  (ma_addr_in),
        .ma_data_in  (ma_data_in),
        .ma_rw_flag  (ma_rw_flag),
        .ma_ce_flag  (ma_ce_flag),
        .ma_data_out (ma_data_out),
`ifdef MEMCTRL_IO_STALL_EN
        .io_buffer_full (io_buffer_full),
`endif
        .if_req      (if_req),
        .if_pc       (if_pc),
        .if_done     (if_done),
        .if_inst     (if_inst),
        .mem_din     (mem_din),
        .mem_dout    (mem_dout),
        .mem_a       (mem_a),
        .mem_wr      (mem_wr)
    );

    always #5 clk = ~clk;

    // Synchronous RAM with a preload port used only while the DUT is in reset.
    logic [7:0]            ram [0:(1<<RAM_ADDR_W)-1];
    logic                  preEn = 1'b0;
    logic [RAM_ADDR_W-1:0] preAddr = '0;
    logic [7:0]            preData = '0;

    always @(posedge clk) begin
        if (preEn) begin
            ram[preAddr] <= preData;
        end else if (mem_wr) begin
            ram[mem_a] <= mem_dout;
        end
        mem_din <= ram[mem_a];
    end

    function automatic logic [31:0] wordAt(input logic [ADDR_W-1:0] pc);
        logic [31:0]       w;
        logic [ADDR_W-1:0] a;
        for (int k = 0; k < 4; k++) begin
            a = pc + ADDR_W'(k);
            w[8*k +: 8] = ram[a[RAM_ADDR_W-1:0]];
        end
        return w;
    endfunction

    // Transaction model: a fetch needs five consecutive mem-free edges after
    // the request edge; any mem-stage access restarts the count from zero.
    logic        mActive;
    logic        mDone;
    int          mRun;
    logic [31:0] mInst;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            mActive <= 1'b0;
            mDone   <= 1'b0;
            mRun    <= 0;
            mInst   <= '0;
        end else if (mDone) begin
            mDone <= 1'b0;
        end else if (!mActive) begin
            if (if_req && !ma_ce_flag) begin
                mActive <= 1'b1;
                mRun    <= 0;
            end
        end else if (!if_req) begin
            mActive <= 1'b0;
        end else if (ma_ce_flag) begin
            mRun <= 0;
        end else if (mRun == 4) begin
            mActive <= 1'b0;
            mDone   <= 1'b1;
            mInst   <= wordAt(if_pc);
        end else begin
            mRun <= mRun + 1;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("[TB] FAIL %s: actual=0x%0h required=0x%0h @%0t",
                     name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, on the falling edge.
    always @(negedge clk) begin
        logic [31:0] expA;
        logic [31:0] expDout;
        logic        expWr;
        logic        ioBlock;
        logic [31:0] t;
        if (checkEn) begin
            expA    = '0;
            expDout = '0;
            expWr   = 1'b0;
            ioBlock = 1'b0;
`ifdef MEMCTRL_IO_STALL_EN
            ioBlock = io_buffer_full && ma_rw_flag && (ma_addr_in[17:16] == 2'b11);
`endif
            if (!rst) begin
                expA = '0;
            end else if (ma_ce_flag) begin
                expA    = {15'd0, ma_addr_in[RAM_ADDR_W-1:0]};
                expDout = {24'd0, ma_data_in};
                expWr   = ma_rw_flag && !ioBlock;
            end else if (mActive && mRun < 4) begin
                t    = if_pc + 32'(mRun);
                expA = {15'd0, t[RAM_ADDR_W-1:0]};
            end
            checkOutput("model mem_a",    {15'd0, mem_a}, expA);
            checkOutput("model mem_wr",   {31'd0, mem_wr}, {31'd0, expWr});
            checkOutput("model mem_dout", {24'd0, mem_dout}, expDout);
            checkOutput("model if_done",  {31'd0, if_done}, {31'd0, mDone});
            checkOutput("model if_inst",  if_inst, mInst);
            checkOutput("model ma_data_out", {24'd0, ma_data_out}, {24'd0, mem_din});
        end
    end

    task automatic applyStimulus(input logic ce, input logic rw,
                                 input logic [31:0] addr, input logic [7:0] data,
                                 input logic req, input logic [31:0] pc);
        @(posedge clk);
        #1;
        ma_ce_flag = ce;
        ma_rw_flag = rw;
        ma_addr_in = addr;
        ma_data_in = data;
        if_req     = req;
        if_pc      = pc;
    endtask

    task automatic preloadByte(input logic [RAM_ADDR_W-1:0] a, input logic [7:0] d);
        preAddr = a;
        preData = d;
        preEn   = 1'b1;
        @(posedge clk);
        #1;
        preEn   = 1'b0;
    endtask

    // Counts cycles (falling edges) until if_done; -1 if the budget runs out.
    task automatic waitDone(input int startN, input int budget, output int n);
        n = startN;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            n = n + 1;
            if (if_done) return;
        end
        n = -1;
    endtask

    task automatic countDone(input int cycles, output int pulses);
        pulses = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (if_done) pulses = pulses + 1;
        end
    endtask

    initial begin
        int n;
        int pulses;
        logic [31:0] wrapExp [4];
        wrapExp[0] = 32'h1FFFE;
        wrapExp[1] = 32'h1FFFF;
        wrapExp[2] = 32'h00000;
        wrapExp[3] = 32'h00001;

        rst        = 1'b0;
        ma_addr_in = '0;
        ma_data_in = '0;
        ma_rw_flag = 1'b0;
        ma_ce_flag = 1'b0;
        if_req     = 1'b0;
        if_pc      = '0;
`ifdef MEMCTRL_IO_STALL_EN
        io_buffer_full = 1'b0;
`endif

        preloadByte(17'h00100, 8'h13);
        preloadByte(17'h00101, 8'h05);
        preloadByte(17'h00102, 8'hA0);
        preloadByte(17'h00103, 8'h00);
        preloadByte(17'h1FFFE, 8'h11);
        preloadByte(17'h1FFFF, 8'h22);
        preloadByte(17'h00000, 8'h33);
        preloadByte(17'h00001, 8'h44);
        preloadByte(17'h00300, 8'h77);

        @(negedge clk);
        checkOutput("reset if_done",  {31'd0, if_done}, 32'd0);
        checkOutput("reset if_inst",  if_inst, 32'd0);
        checkOutput("reset mem_a",    {15'd0, mem_a}, 32'd0);
        checkOutput("reset mem_wr",   {31'd0, mem_wr}, 32'd0);
        checkOutput("reset mem_dout", {24'd0, mem_dout}, 32'd0);
        checkEn = 1'b1;
        @(posedge clk);
        #1 rst = 1'b1;

        // Uncontended fetch of 0x100.
        $display("[TB] uncontended fetch");
        applyStimulus(1'b0, 1'b0, 32'h0, 8'h0, 1'b1, 32'h100);
        @(posedge clk);
        waitDone(0, 20, n);
        checkOutput("t1 latency", 32'(n), 32'd6);
        checkOutput("t1 if_inst", if_inst, 32'h00A00513);
        applyStimulus(1'b0, 1'b0, 32'h0, 8'h0, 1'b0, 32'h100);

        // Mem-stage write then read back.
        $display("[TB] mem-stage write/read");
        applyStimulus(1'b1, 1'b1, 32'h200, 8'h5A, 1'b0, 32'h0);
        @(negedge clk);
        checkOutput("t2 mem_a",    {15'd0, mem_a}, 32'h200);
        checkOutput("t2 mem_wr",   {31'd0, mem_wr}, 32'd1);
        checkOutput("t2 mem_dout", {24'd0, mem_dout}, 32'h5A);
        applyStimulus(1'b1, 1'b0, 32'h200, 8'h00, 1'b0, 32'h0);
        applyStimulus(1'b0, 1'b0, 32'h0, 8'h00, 1'b0, 32'h0);
        @(negedge clk);
        checkOutput("t2 readback", {24'd0, ma_data_out}, 32'h5A);

        // Fetch interrupted by a 2-cycle mem read after two bytes.
        $display("[TB] interrupted fetch");
        applyStimulus(1'b0, 1'b0, 32'h0, 8'h0, 1'b1, 32'h100);
        applyStimulus(1'b0, 1'b0, 32'h0, 8'h0, 1'b1, 32'h100);
        applyStimulus(1'b0, 1'b0, 32'h0, 8'h0, 1'b1, 32'h100);
        applyStimulus(1'b1, 1'b0, 32'h300, 8'h0, 1'b1, 32'h100);
        applyStimulus(1'b1, 1'b0, 32'h300, 8'h0, 1'b1, 32'h100);
        applyStimulus(1'b0, 1'b0, 32'h0, 8'h0, 1'b1, 32'h100);
        @(negedge clk);
        checkOutput("t3 restart addr", {15'd0, mem_a}, 32'h100);
        checkOutput("t3 stall read", {24'd0, ma_data_out}, 32'h77);
        waitDone(5, 20, n);
        checkOutput("t3 latency", 32'(n), 32'd10);
        checkOutput("t3 if_inst", if_inst, 32'h00A00513);
        applyStimulus(1'b0, 1'b0, 32'h0, 8'h0, 1'b0, 32'h100);

        // Flush three cycles into a fetch.
        $display("[TB] flush");
        applyStimulus(1'b0, 1'b0, 32'h0, 8'h0, 1'b1, 32'h100);
        applyStimulus(1'b0, 1'b0, 32'h0, 8'h0, 1'b1, 32'h100);
        applyStimulus(1'b0, 1'b0, 32'h0, 8'h0, 1'b1, 32'h100);
        applyStimulus(1'b0, 1'b0, 32'h0, 8'h0, 1'b1, 32'h100);
        applyStimulus(1'b0, 1'b0, 32'h0, 8'h0, 1'b0, 32'h100);
        applyStimulus(1'b0, 1'b0, 32'h0, 8'h0, 1'b0, 32'h100);
        @(negedge clk);
        checkOutput("t4 mem_a idle", {15'd0, mem_a}, 32'h0);
        countDone(8, pulses);
        checkOutput("t4 no if_done", 32'(pulses), 32'd0);

        // Address wrap at the top of the CPU address space.
        $display("[TB] address wrap");
        applyStimulus(1'b0, 1'b0, 32'h0, 8'h0, 1'b1, 32'hFFFF_FFFE);
        @(posedge clk);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checkOutput("t5 wrap addr", {15'd0, mem_a}, wrapExp[k]);
        end
        waitDone(4, 20, n);
        checkOutput("t5 latency", 32'(n), 32'd6);
        checkOutput("t5 if_inst", if_inst, 32'h44332211);
        applyStimulus(1'b0, 1'b0, 32'h0, 8'h0, 1'b0, 32'h100);

        // Request and mem access arrive together in IDLE.
        $display("[TB] request blocked in idle");
        applyStimulus(1'b1, 1'b0, 32'h300, 8'h0, 1'b1, 32'h100);
        applyStimulus(1'b1, 1'b0, 32'h300, 8'h0, 1'b1, 32'h100);
        applyStimulus(1'b0, 1'b0, 32'h0, 8'h0, 1'b1, 32'h100);
        @(negedge clk);
        checkOutput("t6 still idle", {15'd0, mem_a}, 32'h0);
        @(posedge clk);
        waitDone(0, 20, n);
        checkOutput("t6 latency", 32'(n), 32'd6);
        applyStimulus(1'b0, 1'b0, 32'h0, 8'h0, 1'b0, 32'h100);

        // Reset in the middle of a fetch.
        $display("[TB] reset mid-fetch");
        applyStimulus(1'b0, 1'b0, 32'h0, 8'h0, 1'b1, 32'hFFFF_FFFE);
        applyStimulus(1'b0, 1'b0, 32'h0, 8'h0, 1'b1, 32'hFFFF_FFFE);
        applyStimulus(1'b0, 1'b0, 32'h0, 8'h0, 1'b1, 32'hFFFF_FFFE);
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        checkOutput("t7 reset mem_a",   {15'd0, mem_a}, 32'h0);
        checkOutput("t7 reset if_inst", if_inst, 32'h0);
        checkOutput("t7 reset if_done", {31'd0, if_done}, 32'd0);
        @(posedge clk);
        #1;
        if_req = 1'b0;
        rst    = 1'b1;
        countDone(8, pulses);
        checkOutput("t7 no if_done", 32'(pulses), 32'd0);

`ifdef MEMCTRL_IO_STALL_EN
        // IO-space write held while the IO buffer is full.
        $display("[TB] io stall");
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b1, 1'b1, 32'h30000, 8'hC3, 1'b0, 32'h0);
            io_buffer_full = 1'b1;
            @(negedge clk);
            checkOutput("t8 held mem_wr", {31'd0, mem_wr}, 32'd0);
        end
        applyStimulus(1'b1, 1'b1, 32'h30000, 8'hC3, 1'b0, 32'h0);
        io_buffer_full = 1'b0;
        @(negedge clk);
        checkOutput("t8 release mem_wr",   {31'd0, mem_wr}, 32'd1);
        checkOutput("t8 release mem_dout", {24'd0, mem_dout}, 32'hC3);
        checkOutput("t8 release mem_a",    {15'd0, mem_a}, 32'h10000);
        applyStimulus(1'b0, 1'b0, 32'h0, 8'h0, 1'b0, 32'h0);
`endif

        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
